// File: rtl/poly_axis_tx.sv
// poly_axis_tx: polynomial coefficient source that streams N beats per committed polynomial.
// Defining POLY_TX_PINGPONG_EN gives two banks so loading overlaps streaming; otherwise one bank.
module poly_axis_tx #(
  parameter  int N  = 4,
  parameter  int W  = 5,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          s_rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          commit,
  output logic          wr_rdy,
  output logic [W-1:0]  m_data,
  output logic          m_vld,
  output logic          m_last,
  input  logic          m_rdy
);

`ifdef POLY_TX_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  localparam logic [AW:0]   LAST_IDX = (AW+1)'(N-1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] IDX0     = '0;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] bank [2][N];
  logic [1:0]   full, full_nxt;
  logic         fill_sel, fill_sel_nxt;
  logic         drain_sel, drain_sel_nxt;
  logic [AW:0]  cnt, cnt_nxt, cnt_inc;
  logic [W-1:0] data_nxt, next_head;
  logic         vld_nxt, last_nxt, wr_rdy_nxt;
  logic         wr_ok, commit_ok, accept, next_bank;

  assign wr_ok     = wr_en && wr_rdy;
  assign commit_ok = commit && wr_rdy;
  assign accept    = m_vld && m_rdy;
  assign cnt_inc   = cnt + CNT_ONE;
  assign next_bank = drain_sel ^ PP;

  // A bank committed in the same cycle may also take a write to coefficient 0 that is not yet in storage.
  assign next_head = (wr_ok && (fill_sel == next_bank) && (wr_addr == IDX0)) ?
                     wr_data : bank[next_bank][IDX0];

  always_ff @(posedge clk) begin
    if (s_rst_n && wr_ok) begin
      bank[fill_sel][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    data_nxt      = m_data;
    vld_nxt       = m_vld;
    last_nxt      = m_last;
    full_nxt      = full;
    fill_sel_nxt  = fill_sel;
    drain_sel_nxt = drain_sel;

    if (commit_ok) begin
      full_nxt[fill_sel] = 1'b1;
      fill_sel_nxt       = fill_sel ^ PP;
    end

    case (state)
      IDLE: begin
        if (full[drain_sel]) begin
          state_nxt = STREAM;
          cnt_nxt   = '0;
          data_nxt  = bank[drain_sel][IDX0];
          vld_nxt   = 1'b1;
          last_nxt  = 1'b0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (cnt != LAST_IDX) begin
            cnt_nxt  = cnt_inc;
            data_nxt = bank[drain_sel][cnt_inc[AW-1:0]];
            last_nxt = (cnt_inc == LAST_IDX);
          end else begin
            // Last beat leaves: free the bank and chain straight into the other one if it is ready.
            full_nxt[drain_sel] = 1'b0;
            drain_sel_nxt       = next_bank;
            cnt_nxt             = '0;
            last_nxt            = 1'b0;
            if (full_nxt[next_bank]) begin
              data_nxt = next_head;
              vld_nxt  = 1'b1;
            end else begin
              state_nxt = IDLE;
              vld_nxt   = 1'b0;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    wr_rdy_nxt = ~full_nxt[fill_sel_nxt];
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state     <= IDLE;
      full      <= '0;
      fill_sel  <= 1'b0;
      drain_sel <= 1'b0;
      cnt       <= '0;
      m_data    <= '0;
      m_vld     <= 1'b0;
      m_last    <= 1'b0;
      wr_rdy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      full      <= full_nxt;
      fill_sel  <= fill_sel_nxt;
      drain_sel <= drain_sel_nxt;
      cnt       <= cnt_nxt;
      m_data    <= data_nxt;
      m_vld     <= vld_nxt;
      m_last    <= last_nxt;
      wr_rdy    <= wr_rdy_nxt;
    end
  end

endmodule

// File: doc/poly_axis_tx.md
# poly_axis_tx

Polynomial coefficient transmitter for the FV encryption datapath. It holds one or two complete polynomials of N coefficients written through a random-access load port. It streams each committed polynomial as an AXI-stream sequence of N beats, coefficient 0 first, with `last` on the final beat. It is the source end of the coefficient streams consumed by the polynomial multiplier: one instance drives `p`, another drives `u`. It honours full `vld`/`rdy` backpressure.

## Interface
- `N`, 4: coefficients per polynomial; power of two, ≥2.
- `W`, 5: coefficient width in bits (QW for `p`, UW for `u`).
- `AW`, `$clog2(N)`: load address width; derived, not overridden.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `s_rst_n`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  write one coefficient into the fill bank.
- `wr_addr`  in  AW  coefficient index 0..N-1.
- `wr_data`  in  W  coefficient value.
- `commit`  in  1  single-cycle pulse; marks the fill bank complete.
- `wr_rdy`  out  1  fill bank free; writes and commits accepted only when high.
- `m`  axis_if.out  —  `m.data` (W), `m.vld`, `m.last` driven; `m.rdy` sampled.

## Operation
- Storage: two banks of N×W registers (bank 0, bank 1). Each bank has a `full` flag. `fill_sel` selects the bank being loaded; `drain_sel` selects the bank being streamed.
- `wr_rdy = !full[fill_sel]`, registered.
- Writes or commits with `wr_rdy=0` are ignored. Bank contents and flags are unchanged.
- Write: `wr_en && wr_rdy` stores `wr_data` at `bank[fill_sel][wr_addr]`. Unwritten locations keep stale values; no zero-fill.
- Commit: `commit && wr_rdy` sets `full[fill_sel]` and toggles `fill_sel`.
  - A write in the same cycle as the commit is stored first, then the bank closes.
- Drain FSM, two states:
  - IDLE: `m.vld=0`. If `full[drain_sel]`: load beat 0, `cnt=0`, go to STREAM.
  - STREAM: `m.data=bank[drain_sel][cnt]`, `m.vld=1`, `m.last=(cnt==N-1)`.
    - On accept (`m.vld && m.rdy`) with `cnt<N-1`: `cnt++`.
    - On accept of the last beat: clear `full[drain_sel]` and toggle `drain_sel`.
      - If the other bank is full, present its beat 0 next cycle and stay in STREAM.
      - Otherwise go to IDLE.
- `cnt` is AW+1 bits and wraps to 0 only through the last-beat transition.
- Beats are strictly in index order. No reorder or skip.

## Timing
- Reset values: `m.vld=0`, `m.last=0`, `m.data=0`, `wr_rdy=0`. Both `full` flags are 0, `fill_sel=drain_sel=0`, `cnt=0`, FSM in IDLE. Bank contents are not cleared.
- `wr_rdy` rises on the first edge after `s_rst_n` goes high.
- Latency: commit at edge t with the drain idle gives `m.vld=1` with coeff 0 after edge t+1.
- Throughput: one beat per clock while `m.rdy=1`. With the other bank full, there is no bubble between polynomials.
- AXI rule: once `m.vld` is high, `m.data`, `m.last` and `m.vld` stay stable until accepted. `m.vld` never drops without a transfer.
- Boundary and simultaneous events:
  - Commit in the same cycle as the last-beat accept: both take effect. The drain toggles into the freshly committed bank with no bubble.
  - Both banks full: `wr_rdy=0` until the last beat of the draining bank is accepted. `wr_rdy=1` one cycle after that accept.
  - `m.rdy` low for any number of cycles: the output holds and the counter freezes.
  - `s_rst_n` low mid-stream: on the next edge `m.vld` drops and the partial polynomial is discarded. No `last` is emitted.

## Configuration
- `POLY_TX_PINGPONG_EN` defined: two banks as described. Loading overlaps streaming.
- Not defined: a single bank, so `fill_sel` and `drain_sel` are fixed at 0.
  - `wr_rdy` is low from commit until one cycle after the last-beat accept.
  - A commit in the same cycle as that accept is ignored.
  - Minimum period between polynomials is N+2 cycles plus load time.

## Test plan
- **Basic stream.** Write 3,7,1,30 to addr 0..3, then commit, with `m.rdy=1`.
  - Beats 3,7,1,30 on four consecutive cycles starting commit+1.
  - `last` on beat 30 only.
- **Backpressure.** Same data, with `m.rdy` toggling 1,0,0,1,0,1,1.
  - Each beat is held stable while `rdy=0`.
  - Sequence and `last` are unchanged, with exactly 4 transfers.
- **Ping-pong.** Commit polynomial A=1,2,3,4; load and commit B=5,6,7,8 while A streams.
  - Eight beats 1..8 back-to-back with `last` on 4 and on 8.
  - `wr_rdy=0` after the B commit until the accept of beat 4.
- **Blocked load.** With both banks full, drive `wr_en` with addr 0 and data 31, plus `commit`.
  - Both are ignored and the streamed data is unchanged.
  - With the macro undefined, the same check applies during a single stream.
- **Reset mid-stream.** Assert `s_rst_n=0` after beat 1 is accepted.
  - `m.vld=0` next edge and `wr_rdy=0` during reset, rising 1 cycle after release.
  - No beats appear until a new commit.
- **Commit on last beat.** Pulse commit in the same cycle beat 3 of A is accepted.
  - The next cycle presents B coeff 0 with `m.vld` continuously high.
